// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, data-line modes, default parameters and output routing
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
    typedef enum logic [1:0] {STD, AWMF_SDI, AWMF_PDI} mode_t;
    localparam int DEF_MAX_BITS = 100;
    localparam int DEF_CLK_DIV = 1;
    localparam int DEF_N_CS = 4;
    localparam int DEF_GAP_CYC = 2;
    // returns {pdi, sdi, mosi}: only the line owned by the mode carries the bit
    function automatic logic [2:0] route(input mode_t m, input logic b);
        return {b & (m == AWMF_PDI), b & (m == AWMF_SDI), b & (m == STD)};
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period tick generator
// clk/rst: system clock and async reset; en: count while high, held at zero otherwise;
// tick: high in the last clk cycle of each CLK_DIV-cycle half-period
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_mcs.sv
// spi_master_mcs: multi-chip-select SPI master with Standard and AWMF (SDI/PDI) data lines
// start/cs_sel/bit_count/tx_bits/mode_awmf/use_pdi/cpol/cpha: frame request, latched on accept;
// rx_bits: received frame, updated with done; busy/done/err: status; sclk/cs_n: bus clock and selects;
// mosi/sdi/pdi: data out for Standard / AWMF-serial / AWMF-broadcast; miso/sdo: data in
module spi_master_mcs
    import spi_pkg::*;
#(
    parameter int MAX_BITS = DEF_MAX_BITS,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int N_CS = DEF_N_CS,
    parameter int GAP_CYC = DEF_GAP_CYC,
    localparam int CS_IW = N_CS > 1 ? $clog2(N_CS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CS_IW-1:0]    cs_sel,
    input  logic [15:0]         bit_count,
    input  logic [MAX_BITS-1:0] tx_bits,
    output logic [MAX_BITS-1:0] rx_bits,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                mode_awmf,
    input  logic                use_pdi,
    input  logic                cpol,
    input  logic                cpha,
    output logic                sclk,
    output logic [N_CS-1:0]     cs_n,
    output logic                mosi,
    input  logic                miso,
    output logic                sdi,
    output logic                pdi,
    input  logic                sdo
);
    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    state_t state;
    mode_t mode_q, mode_in;
    logic cpol_q, cpha_q, tick, din, smp, last, bad;
    logic [15:0] n_q, nc;
    logic [16:0] h, hn;
    logic [GW-1:0] g;
    logic [MAX_BITS-1:0] sr, sr0, rxs;
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk (clk),
        .rst (rst),
        .en  (state == SETUP || state == XFER || state == HOLD),
        .tick(tick)
    );
    // sr0 left-aligns the frame so the first bit out is always the MSB of the register;
    // hn is the half-period about to begin, smp says whether its opening edge samples
    always_comb begin
        nc = bit_count > 16'(MAX_BITS) ? 16'(MAX_BITS) : bit_count;
        sr0 = tx_bits << (16'(MAX_BITS) - nc);
        mode_in = !mode_awmf ? STD : use_pdi ? AWMF_PDI : AWMF_SDI;
        din = mode_q == STD ? miso : sdo;
        hn = state == SETUP ? '0 : h + 1'b1;
        smp = ~hn[0] ^ cpha_q;
        last = h == {n_q, 1'b0} - 17'd1;
        bad = {1'b0, cs_sel} >= (CS_IW + 1)'(N_CS);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode_q <= STD;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            n_q <= '0;
            h <= '0;
            g <= '0;
            sr <= '0;
            rxs <= '0;
            rx_bits <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            sclk <= 1'b0;
            cs_n <= '1;
            {pdi, sdi, mosi} <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (bad) err <= 1'b1;
                    else if (nc == 16'd0) begin
                        done <= 1'b1;
                        rx_bits <= '0;
                        cpol_q <= cpol;
                        sclk <= cpol;
                    end else begin
                        state <= SETUP;
                        busy <= 1'b1;
                        cs_n <= ~(N_CS'(1) << cs_sel);
                        sclk <= cpol;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        mode_q <= mode_in;
                        n_q <= nc;
                        sr <= sr0;
                        rxs <= '0;
                        {pdi, sdi, mosi} <= route(mode_in, sr0[MAX_BITS-1]);
                    end
                end
                // the first bit is already on the line from SETUP, so the opening edge never shifts
                SETUP, XFER: if (tick) begin
                    if (state == XFER && last) state <= HOLD;
                    else begin
                        state <= XFER;
                        h <= hn;
                        sclk <= ~sclk;
                        if (smp) rxs <= {rxs[MAX_BITS-2:0], din};
                        else if (hn != 17'd0) begin
                            sr <= sr << 1;
                            {pdi, sdi, mosi} <= route(mode_q, sr[MAX_BITS-2]);
                        end
                    end
                end
                HOLD: if (tick) begin
                    state <= GAP;
                    g <= '0;
                    cs_n <= '1;
                    {pdi, sdi, mosi} <= '0;
                end
                GAP: if (g == GW'(GAP_CYC - 1)) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    rx_bits <= rxs;
                end else g <= g + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_mcs.sv
// tb_spi_master_mcs: randomized self-checking bench with an edge-level SPI slave model
module tb_spi_master_mcs;
    localparam int MB = 100, CD = 3, NCS = 5, GP = 2;
    logic clk = 0, rst = 1, start = 0, mode_awmf = 0, use_pdi = 0, cpol = 0, cpha = 0;
    logic [2:0] cs_sel = 0;
    logic [15:0] bit_count = 0;
    logic [MB-1:0] tx_bits = '0, rx_bits;
    logic busy, done, err, sclk, mosi, sdi, pdi, miso, sdo;
    logic [NCS-1:0] cs_n;
    logic exp_awmf = 0, exp_up = 0, exp_pol = 0, exp_pha = 0, sbit = 0, prev_sclk = 0, prev_low = 0, had_frame = 0;
    logic [2:0] exp_sel = 0;
    logic [MB-1:0] resp = '0, got = '0, prev_rx = '0;
    int exp_n = 0, smp_cnt = 0, edges = 0, low_cyc = 0, viol = 0, hi_run = 0, min_gap = 1000;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    // the idle data input carries the inverse so a wrong input mux is visible
    assign miso = exp_awmf ? ~sbit : sbit;
    assign sdo = exp_awmf ? sbit : ~sbit;
    spi_master_mcs #(.MAX_BITS(MB), .CLK_DIV(CD), .N_CS(NCS), .GAP_CYC(GP)) dut (
        .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .bit_count(bit_count),
        .tx_bits(tx_bits), .rx_bits(rx_bits), .busy(busy), .done(done), .err(err),
        .mode_awmf(mode_awmf), .use_pdi(use_pdi), .cpol(cpol), .cpha(cpha), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso), .sdi(sdi), .pdi(pdi), .sdo(sdo)
    );
    // bus monitor and slave: counts sclk edges, captures the data line on sampling edges,
    // and presents the next response bit after each sampling edge
    always @(posedge clk) begin
        #1;
        if (&cs_n) begin
            if (mosi | sdi | pdi) viol++;
            if (busy && sclk !== exp_pol) viol++;
            if (!prev_low && sclk !== prev_sclk) edges++;
            hi_run++;
        end else begin
            if (cs_n !== ~(5'b1 << exp_sel)) viol++;
            if (exp_awmf ? (mosi | (exp_up ? sdi : pdi)) : (sdi | pdi)) viol++;
            low_cyc++;
            if (!prev_low) begin
                if (had_frame && hi_run < min_gap) min_gap = hi_run;
                had_frame = 1;
                smp_cnt = 0;
                got = '0;
                sbit = resp[exp_n-1];
            end else if (sclk !== prev_sclk) begin
                edges++;
                if ((prev_sclk == exp_pol) ^ exp_pha) begin
                    got = {got[MB-2:0], exp_awmf ? (exp_up ? pdi : sdi) : mosi};
                    smp_cnt++;
                    sbit = smp_cnt < exp_n ? resp[exp_n-1-smp_cnt] : 1'b0;
                end
            end
            hi_run = 0;
        end
        prev_low = ~&cs_n;
        prev_sclk = sclk;
    end
    function automatic logic [MB-1:0] rnd();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[MB-1:0];
    endfunction
    function automatic logic [MB-1:0] mask(input int n);
        logic [MB-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction
    task automatic run_frame(input logic [2:0] sel, input logic [15:0] bc, input logic [MB-1:0] tx,
                             input logic aw, input logic up, input logic pol, input logic pha,
                             input logic [MB-1:0] rs, input string nm);
        int n, d, cyc, xe;
        logic [MB-1:0] m;
        #1;
        n = bc > MB ? MB : int'(bc);
        d = n == 0 ? 1 : 1 + CD * (2 * n + 2) + GP;
        m = mask(n);
        xe = 2 * n + ((n == 0 && pol != exp_pol) ? 1 : 0);
        exp_sel = sel; exp_n = n; exp_awmf = aw; exp_up = up; exp_pol = pol; exp_pha = pha; resp = rs;
        edges = 0; low_cyc = 0; viol = 0;
        cs_sel = sel; bit_count = bc; tx_bits = tx; mode_awmf = aw; use_pdi = up; cpol = pol; cpha = pha;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cs_sel = 3'($urandom); bit_count = 16'($urandom); tx_bits = rnd();
        mode_awmf = 1'($urandom); use_pdi = 1'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < d + 50) begin
            if (cyc == 2 && n > 0) begin
                checks++;
                if (cs_n !== ~(5'b1 << sel)) begin failures++; $display("FAIL %s cs_n: got %b expected %b", nm, cs_n, ~(5'b1 << sel)); end
            end
            if (cyc == d - 1 && n > 0) begin
                checks++;
                if (busy !== 1'b1 || rx_bits !== prev_rx) begin failures++; $display("FAIL %s rx_hold: busy %b rx %h expected busy 1 rx %h", nm, busy, rx_bits, prev_rx); end
            end
            @(posedge clk); #1;
            cyc++;
        end
        #1;
        checks++;
        if (cyc != d) begin failures++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, d); end
        checks++;
        if (rx_bits !== (rs & m)) begin failures++; $display("FAIL %s rx_bits: got %h expected %h", nm, rx_bits, rs & m); end
        checks++;
        if (busy !== 1'b0 || sclk !== pol) begin failures++; $display("FAIL %s done_cycle: busy %b sclk %b expected busy 0 sclk %b", nm, busy, sclk, pol); end
        checks++;
        if (edges != xe) begin failures++; $display("FAIL %s sclk_edges: got %0d expected %0d", nm, edges, xe); end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL %s bus_rules: got %0d violations expected 0", nm, viol); end
        checks++;
        if (n > 0 && got !== (tx & m)) begin failures++; $display("FAIL %s tx_line: got %h expected %h", nm, got, tx & m); end
        else if (n == 0 && low_cyc != 0) begin failures++; $display("FAIL %s cs_idle: got %0d low cycles expected 0", nm, low_cyc); end
        prev_rx = rs & m;
    endtask
    task automatic test_reset;
        checks++;
        if (cs_n !== 5'b11111 || sclk !== 1'b0 || {mosi, sdi, pdi} !== 3'b0) begin failures++; $display("FAIL reset_bus: cs_n %b sclk %b data %b expected 11111 0 000", cs_n, sclk, {mosi, sdi, pdi}); end
        checks++;
        if ({busy, done, err} !== 3'b0) begin failures++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
        checks++;
        if (rx_bits !== '0) begin failures++; $display("FAIL reset_rx: got %h expected 0", rx_bits); end
    endtask
    task automatic test_standard;
        run_frame(0, 8, 100'hA5, 0, 0, 0, 0, 100'hA5, "std_a5");
        run_frame(2, 13, rnd(), 0, 0, 1, 1, rnd(), "std_mode3");
    endtask
    task automatic test_awmf;
        run_frame(3'($urandom_range(0, 4)), 100, rnd(), 1, 1, 1, 1, rnd(), "awmf_pdi");
        run_frame(1, 37, rnd(), 1, 0, 0, 1, rnd(), "awmf_sdi");
    endtask
    task automatic test_zero_len;
        run_frame(1, 0, rnd(), 0, 0, exp_pol, 0, rnd(), "zero_len");
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL zero_len_pulse: done %b expected 0", done); end
    endtask
    task automatic test_clamp;
        run_frame(4, 200, rnd(), 0, 0, 1, 0, rnd(), "clamp_200");
    endtask
    task automatic test_bad_sel;
        int nd, ne;
        #1;
        edges = 0; low_cyc = 0; nd = 0; ne = 0;
        cs_sel = 5; bit_count = 8; tx_bits = rnd(); start = 1;
        @(posedge clk); #1;
        start = 0;
        checks++;
        if ({err, busy, done} !== 3'b100) begin failures++; $display("FAIL bad_sel_c1: err/busy/done %b expected 100", {err, busy, done}); end
        repeat (20) begin
            @(posedge clk); #1;
            nd += int'(done);
            ne += int'(err);
        end
        checks++;
        if (nd != 0 || ne != 0 || low_cyc != 0 || edges != 0 || cs_n !== 5'b11111) begin failures++; $display("FAIL bad_sel_quiet: done %0d err %0d low %0d edges %0d cs_n %b expected 0 0 0 0 11111", nd, ne, low_cyc, edges, cs_n); end
        checks++;
        if (rx_bits !== prev_rx) begin failures++; $display("FAIL bad_sel_rx: got %h expected %h", rx_bits, prev_rx); end
    endtask
    task automatic test_random;
        for (int k = 0; k < 8; k++)
            run_frame(3'($urandom_range(0, 4)), $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 300)) : 16'($urandom_range(1, 60)),
                      rnd(), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rnd(), "random");
    endtask
    task automatic test_reset_mid;
        int nd;
        #1;
        nd = 0;
        exp_sel = 2; exp_n = 40; exp_awmf = 0; exp_up = 0; exp_pol = 1; exp_pha = 0; resp = rnd();
        cs_sel = 2; bit_count = 40; tx_bits = rnd(); mode_awmf = 0; use_pdi = 0; cpol = 1; cpha = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (60) begin
            @(posedge clk); #1;
            nd += int'(done);
        end
        checks++;
        if (cs_n !== 5'b11011 || busy !== 1'b1) begin failures++; $display("FAIL mid_frame: cs_n %b busy %b expected 11011 1", cs_n, busy); end
        #2 rst = 1;
        #1;
        checks++;
        if (cs_n !== 5'b11111 || sclk !== 1'b0 || {busy, done, mosi} !== 3'b0 || rx_bits !== '0) begin failures++; $display("FAIL async_reset: cs_n %b sclk %b busy %b done %b rx %h expected 11111 0 0 0 0", cs_n, sclk, busy, done, rx_bits); end
        exp_pol = 0;
        prev_rx = '0;
        @(posedge clk); #1;
        checks++;
        if (nd != 0 || done !== 1'b0) begin failures++; $display("FAIL abort_done: got %0d done pulses expected 0", nd); end
        rst = 0;
        run_frame(1, 24, rnd(), 1, 1, 0, 1, rnd(), "after_reset");
    endtask
    task automatic test_back_to_back;
        int n, d, cyc, ne;
        logic [MB-1:0] m;
        #1;
        n = 12;
        d = 1 + CD * (2 * n + 2) + GP;
        m = mask(n);
        ne = 0;
        exp_sel = 3; exp_n = n; exp_awmf = 1; exp_up = 0; exp_pol = 1'($urandom); exp_pha = 1'($urandom); resp = rnd();
        cs_sel = 3; bit_count = 16'(n); tx_bits = rnd(); mode_awmf = 1; use_pdi = 0; cpol = exp_pol; cpha = exp_pha;
        viol = 0; had_frame = 0; min_gap = 1000;
        start = 1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
                ne += int'(err);
            end while (done !== 1'b1 && cyc < d + 50);
            checks++;
            if (cyc != d) begin failures++; $display("FAIL b2b_spacing %0d: got %0d expected %0d", k, cyc, d); end
            checks++;
            if (rx_bits !== (resp & m)) begin failures++; $display("FAIL b2b_rx %0d: got %h expected %h", k, rx_bits, resp & m); end
        end
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (min_gap < GP || min_gap == 1000 || ne != 0 || viol != 0) begin failures++; $display("FAIL b2b_gap: min gap %0d err %0d viol %0d expected gap >= %0d err 0 viol 0", min_gap, ne, viol, GP); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop: busy %b expected 0", busy); end
        prev_rx = resp & m;
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 0;
        test_standard;
        test_awmf;
        test_zero_len;
        test_clamp;
        test_bad_sel;
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
